projection_router: RTL and testbench
====================================

PROJECTION_ROUTER -- requirements
Module: projection_router

Interface
REQ-001 Parameter NREG, default 4, number of phi regions (power of two, 2..8).
REQ-002 Parameter DEPTH_BITS, default 6, per-region per-page entry address width.
REQ-003 Parameter ZMAX, default 12'd1800, z fiducial limit (magnitude, used only under the macro in REQ-022).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 start  in  1  new-bunch-crossing pulse, one cycle.
REQ-007 proj_in  in  54  {marker[53:44], phi_proj[43:30] signed 14b, z_proj[29:18] signed 12b, phi_der[17:9], z_der[8:0]}, from the projection calculation stage.
REQ-008 proj_valid  in  1  proj_in valid this cycle.
REQ-009 wr_en  out  NREG  one-hot per-region memory write strobe.
REQ-010 wr_addr  out  DEPTH_BITS+1  {page, entry}.
REQ-011 wr_data  out  54  proj_in forwarded unchanged.
REQ-012 nproj  out  NREG*(DEPTH_BITS+1)  per-region entry counts of the last completed page.
REQ-013 overflow  out  NREG  sticky per-region drop flag.

Function
REQ-014 States: IDLE (after reset), RUN; IDLE->RUN on start; no return to IDLE except reset.
REQ-015 In IDLE all inputs except start are ignored; wr_en stays 0.
REQ-016 Accept = proj_valid & state RUN & marker==10'h3ff (& z cut if enabled); otherwise discard silently.
REQ-017 Region = top log2(NREG) bits of phi_proj taken as unsigned offset (phi_proj[13] inverted, then MSBs).
REQ-018 Accepted word: wr_en[region], wr_addr={page, cnt[region]}, wr_data registered; latency exactly 1 cycle from proj_valid.
REQ-019 cnt[region] increments per accepted word; at 2**DEPTH_BITS the word is dropped, wr_en stays 0, overflow[region] sets, count saturates.
REQ-020 On start: page toggles, nproj latches all cnt values, cnt and overflow clear; start with proj_valid same cycle -> start applied first, word written to new page at entry 0.
REQ-021 Page toggle wraps 1->0; first start after reset selects page 0.

Configuration
REQ-022 Macro PROJ_ZCUT_EN: defined -> words with z_proj > ZMAX or z_proj < -ZMAX dropped without overflow effect; undefined -> no z check, ZMAX unused.

Reset
REQ-023 Reset mid-operation aborts immediately: state IDLE, page=1 (so first start yields 0), wr_en=0, wr_addr=0, wr_data=0, nproj=0, overflow=0, cnt=0.
REQ-024 Reset deassertion is not assumed synchronous to any start; start in the first cycle after deassertion is honoured.

Structure
REQ-025 Shared package holds projection field offsets/widths, MARKER constant 10'h3ff and the proj word typedef, shared with the calculation stage.
REQ-026 One sub-module proj_region_counter (counter, saturation, overflow, latch), instantiated NREG times.

Verification
REQ-027 Reset, no start, 5 valid words -> wr_en stays 0, nproj 0.
REQ-028 start, then words with phi_proj 14'h0000, 14'h1000, 14'h2000, 14'h3000 -> wr_en 4'b0100,1000,0001,0010, wr_addr 7'h00 each, 1-cycle latency.
REQ-029 65 valid words to region 0 in one page -> addresses 0..63, 65th dropped, overflow[0]=1; next start -> nproj[0]=64, overflow clear, page 1.
REQ-030 start and proj_valid same cycle after 3 writes -> word at {~page,0}, nproj shows 3.
REQ-031 Marker 10'h3fe word -> dropped; with PROJ_ZCUT_EN, z_proj 12'sd1801 dropped and 12'sd1800 written.
REQ-032 Reset asserted mid-burst -> outputs zero same cycle asynchronously, IDLE until next start.

Source files
------------

// File: rtl/projection_router_pkg.sv
// Shared definitions for the projection word, used by the calculation stage and by projection_router.
// Field offsets/widths, the valid-word marker and the packed word layout live here.
package projection_router_pkg;

  localparam int PROJ_W        = 54;
  localparam int MARKER_LSB    = 44;
  localparam int MARKER_W      = 10;
  localparam int PHI_PROJ_LSB  = 30;
  localparam int PHI_PROJ_W    = 14;
  localparam int Z_PROJ_LSB    = 18;
  localparam int Z_PROJ_W      = 12;
  localparam int PHI_DER_LSB   = 9;
  localparam int PHI_DER_W     = 9;
  localparam int Z_DER_LSB     = 0;
  localparam int Z_DER_W       = 9;

  localparam logic [MARKER_W-1:0] MARKER = 10'h3ff;

  typedef struct packed {
    logic [MARKER_W-1:0]   marker;
    logic [PHI_PROJ_W-1:0] phi_proj;
    logic [Z_PROJ_W-1:0]   z_proj;
    logic [PHI_DER_W-1:0]  phi_der;
    logic [Z_DER_W-1:0]    z_der;
  } proj_word_t;

  // Signed phi turned into an unsigned offset so the MSBs index regions in phi order.
  function automatic logic [PHI_PROJ_W-1:0] phi_offset(input logic [PHI_PROJ_W-1:0] phi);
    return {~phi[PHI_PROJ_W-1], phi[PHI_PROJ_W-2:0]};
  endfunction

endpackage

// File: rtl/projection_router_if.sv
// Projection input stream and region-memory write port of projection_router.
// Valid-only stream: a word transfers on every cycle proj_valid is high; there is no ready, the sink always accepts.
interface projection_router_if #(
  parameter int NREG       = 4,
  parameter int DEPTH_BITS = 6
);
  import projection_router_pkg::*;

  proj_word_t            proj_in;
  logic                  proj_valid;
  logic [NREG-1:0]       wr_en;
  logic [DEPTH_BITS:0]   wr_addr;
  proj_word_t            wr_data;

  modport master (output proj_in, output proj_valid, input wr_en, input wr_addr, input wr_data);
  modport slave  (input proj_in, input proj_valid, output wr_en, output wr_addr, output wr_data);

endinterface

// File: rtl/projection_router_region_counter.sv
// proj_region_counter: per-region entry counter with saturation, sticky overflow and
// end-of-page latch of the count into nproj.
module proj_region_counter #(
  parameter int DEPTH_BITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  inc,
  output logic [DEPTH_BITS-1:0] entry,
  output logic                  full,
  output logic                  overflow,
  output logic [DEPTH_BITS:0]   nproj
);

  localparam logic [DEPTH_BITS:0] CAP = {1'b1, {DEPTH_BITS{1'b0}}};

  logic [DEPTH_BITS:0] cnt;

  assign entry = cnt[DEPTH_BITS-1:0];
  assign full  = (cnt == CAP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      overflow <= 1'b0;
      nproj    <= '0;
    end else if (clr) begin
      // A word arriving with the page switch is entry 0 of the new page.
      nproj    <= cnt;
      overflow <= 1'b0;
      cnt      <= {{DEPTH_BITS{1'b0}}, inc};
    end else if (inc) begin
      if (full) overflow <= 1'b1;
      else      cnt      <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/projection_router.sv
// projection_router: routes marked projection words into NREG double-paged phi-region memories.
// Optional z fiducial cut is enabled by defining PROJ_ZCUT_EN.
module projection_router
  import projection_router_pkg::*;
#(
  parameter int          NREG       = 4,
  parameter int          DEPTH_BITS = 6,
  parameter logic [11:0] ZMAX       = 12'd1800
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  projection_router_if.slave             bus,
  output logic [NREG*(DEPTH_BITS+1)-1:0] nproj,
  output logic [NREG-1:0]                overflow,
  output logic                           state_dbg
);

  localparam int RB = $clog2(NREG);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]            state;
  logic                  page;
  logic                  run_eff;
  logic                  page_eff;
  logic                  z_ok;
  logic                  accept;
  logic                  do_write;
  logic [RB-1:0]         region;
  logic [NREG-1:0]       inc_vec;
  logic [NREG-1:0]       full_vec;
  logic [DEPTH_BITS-1:0] entry_all [NREG];

  // start takes effect before a word presented in the same cycle.
  assign run_eff  = (state == RUN) | start;
  assign page_eff = start ? ~page : page;
  assign region   = RB'(phi_offset(bus.proj_in.phi_proj) >> (PHI_PROJ_W - RB));

`ifdef PROJ_ZCUT_EN
  assign z_ok = !(($signed(bus.proj_in.z_proj) > $signed(ZMAX)) ||
                  ($signed(bus.proj_in.z_proj) < -$signed(ZMAX)));
`else
  logic unused_zmax;
  assign unused_zmax = ^ZMAX;
  assign z_ok        = 1'b1;
`endif

  assign accept   = bus.proj_valid & run_eff & (bus.proj_in.marker == MARKER) & z_ok;
  assign do_write = accept & (start | ~full_vec[region]);

  for (genvar r = 0; r < NREG; r++) begin : g_region
    assign inc_vec[r] = accept && (region == RB'(r));

    proj_region_counter #(.DEPTH_BITS(DEPTH_BITS)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .clr      (start),
      .inc      (inc_vec[r]),
      .entry    (entry_all[r]),
      .full     (full_vec[r]),
      .overflow (overflow[r]),
      .nproj    (nproj[r*(DEPTH_BITS+1) +: DEPTH_BITS+1])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      page  <= 1'b1;
    end else if (start) begin
      state <= RUN;
      page  <= ~page;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.wr_en   <= '0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else begin
      bus.wr_en <= do_write ? (NREG'(1) << region) : '0;
      if (do_write) begin
        bus.wr_addr <= {page_eff, (start ? {DEPTH_BITS{1'b0}} : entry_all[region])};
        bus.wr_data <= bus.proj_in;
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_projection_router.sv
// Directed-vector bench for projection_router with hand-computed expectations.
// Build with PROJ_ZCUT_EN defined to exercise the z cut expectations.
module tb_projection_router;
  import projection_router_pkg::*;

  localparam int NREG = 4;
  localparam int DB   = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [NREG*(DB+1)-1:0] nproj;
  logic [NREG-1:0] overflow;
  logic state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  projection_router_if #(.NREG(NREG), .DEPTH_BITS(DB)) bus ();

  projection_router #(.NREG(NREG), .DEPTH_BITS(DB), .ZMAX(12'd1800)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .nproj     (nproj),
    .overflow  (overflow),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [53:0] mk(input logic [9:0] m, input logic [13:0] phi, input logic [11:0] z);
    return {m, phi, z, 9'h0a5, 9'h15a};
  endfunction

  // Drive one cycle at the falling edge, then sample just after the rising edge.
  task automatic cyc(input logic s, input logic v, input logic [53:0] w);
    @(negedge clk);
    start          = s;
    bus.proj_valid = v;
    bus.proj_in    = w;
    @(posedge clk);
    #1;
  endtask

  logic [53:0] w;
  logic [6:0]  zaddr;

  initial begin
    bus.proj_valid = 1'b0;
    bus.proj_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_en", 64'(bus.wr_en), 64'h0);
    check("rst_wr_addr", 64'(bus.wr_addr), 64'h0);
    check("rst_wr_data", 64'(bus.wr_data), 64'h0);
    check("rst_nproj", 64'(nproj), 64'h0);
    check("rst_overflow", 64'(overflow), 64'h0);
    check("rst_state", 64'(state_dbg), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // IDLE ignores valid words
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, mk(MARKER, 14'h2000, 12'd0));
      check("idle_wr_en", 64'(bus.wr_en), 64'h0);
    end
    check("idle_nproj", 64'(nproj), 64'h0);

    // First start selects page 0; region decode
    cyc(1'b1, 1'b0, '0);
    check("start_state", 64'(state_dbg), 64'h1);
    w = mk(MARKER, 14'h0000, 12'd5);
    cyc(1'b0, 1'b1, w);
    check("reg_0000_en", 64'(bus.wr_en), 64'h4);
    check("reg_0000_addr", 64'(bus.wr_addr), 64'h00);
    check("reg_0000_data", 64'(bus.wr_data), 64'(w));
    cyc(1'b0, 1'b1, mk(MARKER, 14'h1000, 12'd0));
    check("reg_1000_en", 64'(bus.wr_en), 64'h8);
    check("reg_1000_addr", 64'(bus.wr_addr), 64'h00);
    cyc(1'b0, 1'b1, mk(MARKER, 14'h2000, 12'd0));
    check("reg_2000_en", 64'(bus.wr_en), 64'h1);
    check("reg_2000_addr", 64'(bus.wr_addr), 64'h00);
    cyc(1'b0, 1'b1, mk(MARKER, 14'h3000, 12'd0));
    check("reg_3000_en", 64'(bus.wr_en), 64'h2);
    check("reg_3000_addr", 64'(bus.wr_addr), 64'h00);
    cyc(1'b0, 1'b0, '0);
    check("no_valid_en", 64'(bus.wr_en), 64'h0);

    // Second start: page 1, every region saw one word
    cyc(1'b1, 1'b0, '0);
    check("nproj_ones", 64'(nproj), 64'({7'd1, 7'd1, 7'd1, 7'd1}));
    for (int i = 0; i < 64; i++) begin
      cyc(1'b0, 1'b1, mk(MARKER, 14'h2000, 12'd0));
      if (bus.wr_en !== 4'b0001 || bus.wr_addr !== 7'(7'h40 + i)) begin
        check("fill_en", 64'(bus.wr_en), 64'h1);
        check("fill_addr", 64'(bus.wr_addr), 64'(7'h40 + i));
      end else begin
        n_checks++;
      end
    end
    check("fill_ovf_clear", 64'(overflow), 64'h0);
    cyc(1'b0, 1'b1, mk(MARKER, 14'h2000, 12'd0));
    check("word65_en", 64'(bus.wr_en), 64'h0);
    check("word65_ovf", 64'(overflow), 64'h1);
    cyc(1'b0, 1'b1, mk(MARKER, 14'h2000, 12'd0));
    check("word66_en", 64'(bus.wr_en), 64'h0);

    // Third start: page 0, region 0 reports 64
    cyc(1'b1, 1'b0, '0);
    check("nproj_64", 64'(nproj), 64'({7'd0, 7'd0, 7'd0, 7'd64}));
    check("ovf_cleared", 64'(overflow), 64'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, mk(MARKER, 14'h3000, 12'd0));
      check("r1_en", 64'(bus.wr_en), 64'h2);
      check("r1_addr", 64'(bus.wr_addr), 64'(i));
    end

    // start together with a word: new page (1), entry 0
    w = mk(MARKER, 14'h3000, 12'd7);
    cyc(1'b1, 1'b1, w);
    check("same_en", 64'(bus.wr_en), 64'h2);
    check("same_addr", 64'(bus.wr_addr), 64'h40);
    check("same_data", 64'(bus.wr_data), 64'(w));
    check("same_nproj", 64'(nproj), 64'({7'd0, 7'd0, 7'd3, 7'd0}));
    cyc(1'b0, 1'b1, mk(MARKER, 14'h3000, 12'd0));
    check("after_same_addr", 64'(bus.wr_addr), 64'h41);

    // Wrong marker dropped
    cyc(1'b0, 1'b1, mk(10'h3fe, 14'h3000, 12'd0));
    check("marker_drop", 64'(bus.wr_en), 64'h0);

    // z fiducial limits
    zaddr = 7'h42;
    cyc(1'b0, 1'b1, mk(MARKER, 14'h3000, 12'd1801));
`ifdef PROJ_ZCUT_EN
    check("z1801_en", 64'(bus.wr_en), 64'h0);
    cyc(1'b0, 1'b1, mk(MARKER, 14'h3000, 12'h8f7));
    check("zm1801_en", 64'(bus.wr_en), 64'h0);
    check("z_ovf", 64'(overflow), 64'h0);
`else
    check("z1801_en", 64'(bus.wr_en), 64'h2);
    check("z1801_addr", 64'(bus.wr_addr), 64'h42);
    zaddr = 7'h43;
`endif
    cyc(1'b0, 1'b1, mk(MARKER, 14'h3000, 12'd1800));
    check("z1800_en", 64'(bus.wr_en), 64'h2);
    check("z1800_addr", 64'(bus.wr_addr), 64'(zaddr));

    // Reset mid-burst clears outputs without waiting for a clock
    cyc(1'b0, 1'b1, mk(MARKER, 14'h0000, 12'd0));
    check("burst_en", 64'(bus.wr_en), 64'h4);
    #2;
    reset = 1'b1;
    #1;
    check("async_wr_en", 64'(bus.wr_en), 64'h0);
    check("async_wr_addr", 64'(bus.wr_addr), 64'h0);
    check("async_wr_data", 64'(bus.wr_data), 64'h0);
    check("async_nproj", 64'(nproj), 64'h0);
    check("async_ovf", 64'(overflow), 64'h0);
    check("async_state", 64'(state_dbg), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b1, mk(MARKER, 14'h0000, 12'd0));
      check("post_rst_idle_en", 64'(bus.wr_en), 64'h0);
    end

    // start in the very first cycle after reset release
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    bus.proj_valid = 1'b0;
    @(negedge clk);
    w = mk(MARKER, 14'h1000, 12'd3);
    reset          = 1'b0;
    start          = 1'b1;
    bus.proj_valid = 1'b1;
    bus.proj_in    = w;
    @(posedge clk);
    #1;
    check("first_cycle_en", 64'(bus.wr_en), 64'h8);
    check("first_cycle_addr", 64'(bus.wr_addr), 64'h00);
    check("first_cycle_data", 64'(bus.wr_data), 64'(w));
    check("first_cycle_state", 64'(state_dbg), 64'h1);
    cyc(1'b0, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
